step_sequencer: RTL and testbench
=================================

STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 Parameter ADDR_W, default 4: width of the program address counter.
REQ-002 Parameter LAST_ADDR, default 15: final address before wrap to 0; SHALL be ≤ 2^ADDR_W-1.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; forces all state to reset values immediately.
REQ-005 step  input  1  one-cycle debounced pushbutton pulse; starts one instruction sequence.
REQ-006 run  input  1  level; 1 = free-run consecutive instructions, 0 = single-step.
REQ-007 halt  input  1  level; stops free-run at the next instruction boundary.
REQ-008 addr  output  ADDR_W  current instruction address to program memory.
REQ-009 ir_ld  output  1  FETCH strobe: load instruction register.
REQ-010 rf_rd  output  1  READ strobe: register-file read / operand latch.
REQ-011 alu_en  output  1  EXEC strobe: ALU operation latch.
REQ-012 rf_wr  output  1  WB strobe: register-file write.
REQ-013 busy  output  1  high whenever the FSM is not IDLE.
REQ-014 done  output  1  one-cycle pulse in the cycle after WB, when the instruction retires.
REQ-015 wrap  output  1  sticky flag; set when addr wraps from LAST_ADDR to 0.
REQ-016 ovr_cnt  output  8  ignored-step count (see Configuration).

Function
REQ-017 FSM states: IDLE, FETCH, READ, EXEC, WB; each non-IDLE state lasts exactly one cycle.
REQ-018 IDLE -> FETCH on step=1; otherwise remain in IDLE.
REQ-019 FETCH -> READ -> EXEC -> WB unconditionally.
REQ-020 WB -> FETCH if run=1 and halt=0 (sampled in WB); otherwise WB -> IDLE.
REQ-021 Strobes are one-hot and registered with the state: ir_ld only in FETCH, rf_rd only in READ, alu_en only in EXEC, rf_wr only in WB; all low in IDLE.
REQ-022 Latency: step high in cycle N -> ir_ld high in cycle N+1, rf_wr in N+4, done in N+5.
REQ-023 addr is stable through FETCH..WB and increments by 1 on the WB->next-state transition.
REQ-024 At WB with addr=LAST_ADDR, addr becomes 0 and wrap is set; wrap clears only on reset.
REQ-025 done is asserted for one cycle in the cycle following every WB, including in free-run, where it coincides with the next FETCH.
REQ-026 step while busy=1 has no effect on the FSM; an instruction is never aborted or restarted.
REQ-027 step in the same cycle as the WB->IDLE transition is ignored; a new sequence needs step while in IDLE.
REQ-028 halt asserted mid-sequence never truncates the current instruction; it only suppresses WB->FETCH.
REQ-029 run=1 with halt=1 behaves as single-step.

Reset
REQ-030 On reset: state=IDLE, addr=0, all strobes 0, busy=0, done=0, wrap=0, ovr_cnt=0.
REQ-031 Reset asserted mid-sequence aborts immediately, with no rf_wr pulse; after release the FSM waits in IDLE for step.

Configuration
REQ-032 Macro STEP_OVERRUN_CNT_EN: when defined, ovr_cnt increments by 1 for each step pulse that arrives while busy=1 or in the ignored cycle of REQ-027, and saturates at 255.
REQ-033 Without STEP_OVERRUN_CNT_EN: no counter logic is built and ovr_cnt is tied to 8'd0; all other behaviour is identical.

Verification
REQ-034 Reset, single step pulse, run=0 -> ir_ld, rf_rd, alu_en, rf_wr high in consecutive cycles 1..4 after step; done in cycle 5; addr 0->1; busy high for 4 cycles.
REQ-035 run=1, halt=0, one step -> back-to-back instructions every 4 cycles, addr 0,1,2,...; halt raised during EXEC of addr 3 -> WB completes, addr=4, FSM returns to IDLE.
REQ-036 LAST_ADDR=15, 16 single steps from addr 0 -> addr=0, wrap=1; 17th step -> addr=1, wrap still 1.
REQ-037 With STEP_OVERRUN_CNT_EN, 3 step pulses during READ/EXEC/WB -> ovr_cnt=3 and only one instruction executes; 300 such pulses -> ovr_cnt=255; without the macro ovr_cnt=0 throughout.
REQ-038 Reset asserted during EXEC at addr=5 -> outputs go to reset values asynchronously, no rf_wr seen, addr=0; next step runs normally from addr 0.

Source files
------------

// File: rtl/step_sequencer.sv
// Five-phase instruction step sequencer (IDLE, FETCH, READ, EXEC, WB).
//
// A step pulse in IDLE runs one instruction. Each instruction spends one cycle
// in each of FETCH, READ, EXEC and WB, driving the matching one-hot strobe.
// With run=1 and halt=0 sampled in WB, the next instruction starts without
// returning to IDLE. addr advances at every WB and wraps from LAST_ADDR to 0,
// which sets the sticky wrap flag.
//
// Optional feature macro: STEP_OVERRUN_CNT_EN
//   When defined, ovr_cnt counts step pulses that arrive while the sequencer
//   is busy, saturating at 255. When undefined, ovr_cnt is tied to zero.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-high reset
//   step     one-cycle start pulse
//   run      1 = free-run, 0 = single-step
//   halt     stops free-run at the next instruction boundary
//   addr     current instruction address
//   ir_ld    FETCH strobe
//   rf_rd    READ strobe
//   alu_en   EXEC strobe
//   rf_wr    WB strobe
//   busy     high whenever not IDLE
//   done     one-cycle pulse in the cycle after WB
//   wrap     sticky address-wrap flag
//   ovr_cnt  ignored-step count
module step_sequencer #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned LAST_ADDR = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic              run,
  input  logic              halt,
  output logic [ADDR_W-1:0] addr,
  output logic              ir_ld,
  output logic              rf_rd,
  output logic              alu_en,
  output logic              rf_wr,
  output logic              busy,
  output logic              done,
  output logic              wrap,
  output logic [7:0]        ovr_cnt
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(LAST_ADDR);

  typedef enum logic [2:0] {StIdle, StFetch, StRead, StExec, StWb} state_e;

  state_e state;

  // Strobes, busy and done are registered alongside the state so that each
  // output is a clean flop output aligned with the phase it marks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= StIdle;
      addr   <= '0;
      ir_ld  <= 1'b0;
      rf_rd  <= 1'b0;
      alu_en <= 1'b0;
      rf_wr  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      ir_ld  <= 1'b0;
      rf_rd  <= 1'b0;
      alu_en <= 1'b0;
      rf_wr  <= 1'b0;
      done   <= 1'b0;
      case (state)
        StIdle: begin
          if (step) begin
            state <= StFetch;
            ir_ld <= 1'b1;
            busy  <= 1'b1;
          end
        end
        StFetch: begin
          state <= StRead;
          rf_rd <= 1'b1;
        end
        StRead: begin
          state  <= StExec;
          alu_en <= 1'b1;
        end
        StExec: begin
          state <= StWb;
          rf_wr <= 1'b1;
        end
        StWb: begin
          done <= 1'b1;
          if (addr == LastAddr) begin
            addr <= '0;
            wrap <= 1'b1;
          end else begin
            addr <= addr + ADDR_W'(1);
          end
          // step in this cycle is deliberately not looked at: a new sequence
          // from IDLE needs a fresh pulse.
          if (run && !halt) begin
            state <= StFetch;
            ir_ld <= 1'b1;
          end else begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef STEP_OVERRUN_CNT_EN
  // Any step seen outside IDLE is ignored by the FSM, including the one in
  // the WB cycle that returns to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovr_cnt <= 8'd0;
    end else if (step && (state != StIdle) && (ovr_cnt != 8'hff)) begin
      ovr_cnt <= ovr_cnt + 8'd1;
    end
  end
`else
  assign ovr_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_step_sequencer.sv
module tb_step_sequencer;

  localparam int unsigned AddrW    = 4;
  localparam int unsigned LastAddr = 15;
  localparam int          VecW     = AddrW + 7 + 8;

  logic             clk;
  logic             reset;
  logic             step;
  logic             run;
  logic             halt;
  logic [AddrW-1:0] addr;
  logic             ir_ld;
  logic             rf_rd;
  logic             alu_en;
  logic             rf_wr;
  logic             busy;
  logic             done;
  logic             wrap;
  logic [7:0]       ovr_cnt;

  int checks;
  int errors;

  step_sequencer #(
    .ADDR_W   (AddrW),
    .LAST_ADDR(LastAddr)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .step   (step),
    .run    (run),
    .halt   (halt),
    .addr   (addr),
    .ir_ld  (ir_ld),
    .rf_rd  (rf_rd),
    .alu_en (alu_en),
    .rf_wr  (rf_wr),
    .busy   (busy),
    .done   (done),
    .wrap   (wrap),
    .ovr_cnt(ovr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an instruction is a 4-cycle window; m_k counts the
  // cycle within the window that is currently visible on the outputs.
  bit m_busy;
  int m_k;
  int m_addr;
  bit m_wrap;
  bit m_done;
  int m_ovr;

  logic [VecW-1:0] dut_vec;
  assign dut_vec = {addr, ir_ld, rf_rd, alu_en, rf_wr, busy, done, wrap, ovr_cnt};

  function automatic logic [VecW-1:0] exp_vec();
    logic [7:0] ovr;
`ifdef STEP_OVERRUN_CNT_EN
    ovr = 8'(m_ovr);
`else
    ovr = 8'd0;
`endif
    return {AddrW'(m_addr), m_busy && m_k == 0, m_busy && m_k == 1, m_busy && m_k == 2,
            m_busy && m_k == 3, m_busy, m_done, m_wrap, ovr};
  endfunction

  task automatic model_clear();
    m_busy = 0; m_k = 0; m_addr = 0; m_wrap = 0; m_done = 0; m_ovr = 0;
  endtask

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic tick();
    bit s, r, h;
    s = step; r = run; h = halt;
    @(posedge clk);
    m_done = 0;
    if (!m_busy) begin
      if (s) begin
        m_busy = 1;
        m_k = 0;
      end
    end else begin
      if (s && m_ovr < 255) m_ovr++;
      if (m_k == 3) begin
        m_done = 1;
        if (m_addr == LastAddr) begin
          m_addr = 0;
          m_wrap = 1;
        end else begin
          m_addr++;
        end
        if (r && !h) m_k = 0;
        else m_busy = 0;
      end else begin
        m_k++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    step = 0; run = 0; halt = 0;
    do_reset();
    checks++;
    if (dut_vec !== {VecW{1'b0}}) begin
      errors++;
      $display("FAIL reset_state got %h want %h", dut_vec, {VecW{1'b0}});
    end
    tick();
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_idle got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_single_step();
    logic [3:0] seen;
    int busy_cycles;
    busy_cycles = 0;
    do_reset();
    step = 1;
    tick();
    step = 0;
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL single_step cyc%0d got %h want %h", c, dut_vec, exp_vec());
      end
      if (c <= 4) seen = {ir_ld, rf_rd, alu_en, rf_wr};
      if (c <= 4) begin
        checks++;
        if (seen !== 4'(8 >> (c - 1))) begin
          errors++;
          $display("FAIL strobe_cyc%0d got %b want %b", c, seen, 4'(8 >> (c - 1)));
        end
      end
      if (c == 5) begin
        checks++;
        if (done !== 1'b1 || addr !== 4'd1) begin
          errors++;
          $display("FAIL done_addr got done=%b addr=%0d want done=1 addr=1", done, addr);
        end
      end
      if (busy) busy_cycles++;
      tick();
    end
    checks++;
    if (busy_cycles != 4) begin
      errors++;
      $display("FAIL busy_len got %0d want 4", busy_cycles);
    end
  endtask

  task automatic test_free_run_halt();
    bit found;
    int n;
    do_reset();
    run = 1; halt = 0; step = 1;
    tick();
    step = 0;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL free_run cyc%0d got %h want %h", c, dut_vec, exp_vec());
      end
      if (alu_en && addr == 4'd3) found = 1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL free_run_exec3 got not_seen want seen");
    end
    halt = 1;
    n = 0;
    while (n < 10) begin
      tick();
      n++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL halt_seq got %h want %h", dut_vec, exp_vec());
      end
      if (!busy) break;
    end
    checks++;
    if (busy !== 1'b0 || addr !== 4'd4) begin
      errors++;
      $display("FAIL halt_stop got busy=%b addr=%0d want busy=0 addr=4", busy, addr);
    end
    halt = 0; run = 0;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step = 1;
      tick();
      step = 0;
      for (int c = 0; c < 5; c++) begin
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++;
          $display("FAIL wrap_step%0d got %h want %h", i, dut_vec, exp_vec());
        end
        tick();
      end
      if (i == 15) begin
        checks++;
        if (addr !== 4'd0 || wrap !== 1'b1) begin
          errors++;
          $display("FAIL wrap16 got addr=%0d wrap=%b want addr=0 wrap=1", addr, wrap);
        end
      end
    end
    checks++;
    if (addr !== 4'd1 || wrap !== 1'b1) begin
      errors++;
      $display("FAIL wrap17 got addr=%0d wrap=%b want addr=1 wrap=1", addr, wrap);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] want;
    do_reset();
    step = 1; tick();          // FETCH visible
    step = 0; tick();          // READ visible
    step = 1; tick();          // pulse in READ
    tick();                    // pulse in EXEC
    tick();                    // pulse in WB (ignored cycle)
    step = 0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL overrun3_seq got %h want %h", dut_vec, exp_vec());
      end
      tick();
    end
`ifdef STEP_OVERRUN_CNT_EN
    want = 8'd3;
`else
    want = 8'd0;
`endif
    checks++;
    if (ovr_cnt !== want || addr !== 4'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL overrun3 got ovr=%0d addr=%0d busy=%b want ovr=%0d addr=1 busy=0",
               ovr_cnt, addr, busy, want);
    end
    run = 1; step = 1;
    for (int c = 0; c < 302; c++) tick();
    step = 0; halt = 1;
    for (int c = 0; c < 8; c++) tick();
`ifdef STEP_OVERRUN_CNT_EN
    want = 8'd255;
`else
    want = 8'd0;
`endif
    checks++;
    if (ovr_cnt !== want || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL overrun_sat got %h want %h (ovr want %0d)", dut_vec, exp_vec(), want);
    end
    run = 0; halt = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step = 1; tick(); step = 0;
      for (int c = 0; c < 5; c++) tick();
    end
    step = 1; tick(); step = 0;
    tick(); tick();
    checks++;
    if (alu_en !== 1'b1 || addr !== 4'd5 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL mid_exec got %h want %h", dut_vec, exp_vec());
    end
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    checks++;
    if (dut_vec !== {VecW{1'b0}}) begin
      errors++;
      $display("FAIL async_reset got %h want %h", dut_vec, {VecW{1'b0}});
    end
    @(posedge clk);
    #1;
    checks++;
    if (rf_wr !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_hold got %h want %h", dut_vec, exp_vec());
    end
    reset = 1'b0;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL post_reset_idle got %h want %h", dut_vec, exp_vec());
    end
    step = 1; tick(); step = 0;
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (addr !== 4'd1 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL post_reset_run got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      step = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) run = ~run;
      halt = ($urandom_range(0, 4) == 0);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc%0d got %h want %h", c, dut_vec, exp_vec());
      end
    end
    step = 0; run = 0; halt = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    step = 0; run = 0; halt = 0;
    model_clear();
    test_reset();
    test_single_step();
    test_free_run_halt();
    test_wrap();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
